// File: rtl/match_cnt_pkg.sv
// Shared types and helpers for the match window counter.
// Sizes the count field and defines the output-side buffer state.
package match_cnt_pkg;

    // Width able to hold every count from 0 to window inclusive.
    function automatic int cnt_w(input int window);
        return $clog2(window + 1);
    endfunction

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Saturation ceiling of the running total at its default 16-bit width.
    localparam int unsigned TOT_MAX = 32'h0000_FFFF;

endpackage

// File: rtl/match_out_buf.sv
// One-deep valid/ready buffer for closed-window counts.
// Tracks a sticky overrun when a count arrives while the slot is still occupied.
module match_out_buf
    import match_cnt_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_data,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic             cnt_valid,
    output logic [CNT_W-1:0] cnt_data,
    output logic             overrun
);

    out_state_e       state_q, state_d;
    logic [CNT_W-1:0] data_q, data_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (clr_ovr) ovr_d = 1'b0;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                    data_d  = load_data;
                end
            end
            FULL: begin
                if (load) begin
                    // Drop wins over clear, so the set lands after the clear above.
                    if (out_ready) data_d = load_data;
                    else           ovr_d  = 1'b1;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cnt_valid = (state_q == FULL);
    assign cnt_data  = data_q;
    assign overrun   = ovr_q;

endmodule

// File: rtl/match_window_counter.sv
// Counts detector match pulses over fixed windows of bit slots and hands each
// window's count to a slow consumer; also keeps a saturating running total.
module match_window_counter
    import match_cnt_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = cnt_w(WINDOW),
    parameter int TOT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bit_valid,
    input  logic                      match,
    input  logic                      out_ready,
    input  logic                      clr_ovr,
    output logic                      cnt_valid,
    output logic [CNT_W-1:0]          cnt_data,
    output logic [$clog2(WINDOW)-1:0] slot_idx,
    output logic [TOT_W-1:0]          total,
    output logic                      overrun
);

    localparam int SLOT_W = $clog2(WINDOW);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WINDOW - 1);

    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  fin;
    logic              load;

    always_comb begin
        acc_d   = acc_q;
        slot_d  = slot_q;
        total_d = total_q;
        load    = 1'b0;
        fin     = acc_q + CNT_W'(match);
        if (bit_valid) begin
            if (slot_q == LAST_SLOT) begin
                load   = 1'b1;
                acc_d  = '0;
                slot_d = '0;
            end else begin
                acc_d  = fin;
                slot_d = slot_q + SLOT_W'(1);
            end
            if (match && (total_q != {TOT_W{1'b1}})) total_d = total_q + TOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            slot_q  <= '0;
            total_q <= '0;
        end else begin
            acc_q   <= acc_d;
            slot_q  <= slot_d;
            total_q <= total_d;
        end
    end

    match_out_buf #(.CNT_W(CNT_W)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (fin),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .cnt_valid (cnt_valid),
        .cnt_data  (cnt_data),
        .overrun   (overrun)
    );

    assign slot_idx = slot_q;
    assign total    = total_q;

endmodule

// File: tb/tb_match_window_counter.sv
// Directed bench for match_window_counter with WINDOW=4 and a 3-bit total.
module tb_match_window_counter;

    logic       clk = 1'b0;
    logic       rst, bit_valid, match, out_ready, clr_ovr;
    logic       cnt_valid, overrun;
    logic [2:0] cnt_data;
    logic [1:0] slot_idx;
    logic [2:0] total;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    match_window_counter #(.WINDOW(4), .CNT_W(3), .TOT_W(3)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .match(match),
        .out_ready(out_ready), .clr_ovr(clr_ovr), .cnt_valid(cnt_valid),
        .cnt_data(cnt_data), .slot_idx(slot_idx), .total(total), .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic m);
        bit_valid = 1'b1; match = m;
        tick();
        bit_valid = 1'b0; match = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_valid = 1'b0; match = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_valid = 1'b1; match = 1'b1; out_ready = 1'b1; clr_ovr = 1'b0;
        tick(); tick();
        rst = 1'b0; bit_valid = 1'b0; match = 1'b0; out_ready = 1'b0;
        vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL reset cnt_valid got %0d want 0", cnt_valid); end
        vectors++; if (cnt_data !== 3'd0) begin miscompares++; $display("FAIL reset cnt_data got %0d want 0", cnt_data); end
        vectors++; if (slot_idx !== 2'd0) begin miscompares++; $display("FAIL reset slot_idx got %0d want 0", slot_idx); end
        vectors++; if (total !== 3'd0) begin miscompares++; $display("FAIL reset total got %0d want 0", total); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset overrun got %0d want 0", overrun); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        slot(1'b1); slot(1'b0);
        vectors++; if (slot_idx !== 2'd2) begin miscompares++; $display("FAIL basic mid slot_idx got %0d want 2", slot_idx); end
        vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL basic mid cnt_valid got %0d want 0", cnt_valid); end
        slot(1'b1); slot(1'b1);
        vectors++; if (cnt_valid !== 1'b1) begin miscompares++; $display("FAIL basic cnt_valid got %0d want 1", cnt_valid); end
        vectors++; if (cnt_data !== 3'd3) begin miscompares++; $display("FAIL basic cnt_data got %0d want 3", cnt_data); end
        vectors++; if (total !== 3'd3) begin miscompares++; $display("FAIL basic total got %0d want 3", total); end
        vectors++; if (slot_idx !== 2'd0) begin miscompares++; $display("FAIL basic slot_idx got %0d want 0", slot_idx); end
        tick();  // pop with no close
        vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL basic pop cnt_valid got %0d want 0", cnt_valid); end
        vectors++; if (cnt_data !== 3'd3) begin miscompares++; $display("FAIL basic pop cnt_data got %0d want 3", cnt_data); end
    endtask

    // Bits go through a small 101 overlapping detector; each bit slot is
    // followed by an idle cycle that must leave slot_idx untouched.
    task automatic test_gaps();
        logic [7:0] bits;
        logic [1:0] hist;
        logic       m;
        logic [1:0] exp_slot;
        bits = 8'b0001_0101;  // LSB first: 1,0,1,0,1,0,0,0
        hist = 2'b00;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            m = (hist == 2'b10) && bits[k];
            hist = {hist[0], bits[k]};
            slot(m);
            exp_slot = 2'(k + 1);
            if (k == 3 || k == 7) begin
                vectors++; if (cnt_valid !== 1'b1 || cnt_data !== 3'd1) begin miscompares++; $display("FAIL gaps close%0d valid/data got %0d/%0d want 1/1", k, cnt_valid, cnt_data); end
            end
            tick();
            vectors++; if (slot_idx !== exp_slot) begin miscompares++; $display("FAIL gaps idle slot%0d slot_idx got %0d want %0d", k, slot_idx, exp_slot); end
        end
        vectors++; if (total !== 3'd2) begin miscompares++; $display("FAIL gaps total got %0d want 2", total); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) slot(1'b1);
        vectors++; if (cnt_valid !== 1'b1 || cnt_data !== 3'd4) begin miscompares++; $display("FAIL bp first valid/data got %0d/%0d want 1/4", cnt_valid, cnt_data); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL bp first overrun got %0d want 0", overrun); end
        slot(1'b1); slot(1'b0); slot(1'b0); slot(1'b1);  // second window count 2 is dropped
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL bp drop overrun got %0d want 1", overrun); end
        vectors++; if (cnt_data !== 3'd4) begin miscompares++; $display("FAIL bp held cnt_data got %0d want 4", cnt_data); end
        slot(1'b1); slot(1'b1); slot(1'b1);
        clr_ovr = 1'b1;
        slot(1'b1);
        clr_ovr = 1'b0;
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL bp set-over-clear overrun got %0d want 1", overrun); end
        vectors++; if (total !== 3'd7) begin miscompares++; $display("FAIL bp total got %0d want 7", total); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL bp clear overrun got %0d want 0", overrun); end
        vectors++; if (cnt_valid !== 1'b1 || cnt_data !== 3'd4) begin miscompares++; $display("FAIL bp stable valid/data got %0d/%0d want 1/4", cnt_valid, cnt_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        slot(1'b1); slot(1'b1); slot(1'b1); slot(1'b0);
        vectors++; if (cnt_data !== 3'd3) begin miscompares++; $display("FAIL b2b first cnt_data got %0d want 3", cnt_data); end
        slot(1'b1); slot(1'b0); slot(1'b1);
        out_ready = 1'b1;
        slot(1'b0);
        out_ready = 1'b0;
        vectors++; if (cnt_valid !== 1'b1) begin miscompares++; $display("FAIL b2b reload cnt_valid got %0d want 1", cnt_valid); end
        vectors++; if (cnt_data !== 3'd2) begin miscompares++; $display("FAIL b2b reload cnt_data got %0d want 2", cnt_data); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b reload overrun got %0d want 0", overrun); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) slot(1'b1);
        vectors++; if (total !== 3'd7) begin miscompares++; $display("FAIL sat total got %0d want 7", total); end
        vectors++; if (slot_idx !== 2'd1) begin miscompares++; $display("FAIL sat slot_idx got %0d want 1", slot_idx); end
        slot(1'b1);
        vectors++; if (total !== 3'd7) begin miscompares++; $display("FAIL sat hold total got %0d want 7", total); end
        // Reset lands on slot 2 of a partially filled window.
        rst = 1'b1; bit_valid = 1'b1; match = 1'b1;
        tick();
        rst = 1'b0; bit_valid = 1'b0; match = 1'b0;
        vectors++; if (slot_idx !== 2'd0 || total !== 3'd0 || cnt_valid !== 1'b0) begin miscompares++; $display("FAIL sat rst slot/total/valid got %0d/%0d/%0d want 0/0/0", slot_idx, total, cnt_valid); end
        slot(1'b0); slot(1'b0); slot(1'b0); slot(1'b1);
        vectors++; if (cnt_valid !== 1'b1 || cnt_data !== 3'd1) begin miscompares++; $display("FAIL sat fresh window valid/data got %0d/%0d want 1/1", cnt_valid, cnt_data); end
    endtask

    initial begin
        rst = 1'b1; bit_valid = 1'b0; match = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
